// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad encoder.
//   - Key code constants for the operator keys.
//   - FSM state encoding used by keypad_encoder.
//   - keymap(): row/column position to key code.
package keypad_pkg;

  localparam logic [3:0] KEY_EQUAL = 4'hA;
  localparam logic [3:0] KEY_AC    = 4'hB;
  localparam logic [3:0] KEY_PLUS  = 4'hC;
  localparam logic [3:0] KEY_MINUS = 4'hD;
  localparam logic [3:0] KEY_MULT  = 4'hE;
  localparam logic [3:0] KEY_DIV   = 4'hF;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebPress = 2'd1,
    StHeld     = 2'd2,
    StDebRel   = 2'd3
  } kp_state_e;

  // Board layout:
  //   row0: 1 2 3 +
  //   row1: 4 5 6 -
  //   row2: 7 8 9 *
  //   row3: AC 0 = /
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    unique case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_PLUS;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_MINUS;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_MULT;
      4'b11_00: code = KEY_AC;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_EQUAL;
      4'b11_11: code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Row scanner for the 4x4 keypad.
//   Synchronises the columns, drives one row low at a time for SCAN_DIV cycles each and
//   accumulates the contacts seen over a full pass (rows 0..3).
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous reset, active-low
//   col_n      in   [3:0] raw keypad columns, 0 = contact
//   row_n      out  [3:0] row drive, exactly one bit low
//   pass_done  out  1-cycle strobe on the last cycle of a pass
//   key_count  out  [4:0] contacts seen during the pass (valid with pass_done)
//   key_code   out  [3:0] code of the first contact seen (valid with pass_done)
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       pass_done,
  output logic [4:0] key_count,
  output logic [3:0] key_code
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]      col_meta_q, col_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [4:0]      acc_count_q, acc_count_d;
  logic [3:0]      acc_code_q, acc_code_d;
  logic            sample;
  logic [3:0]      contacts;
  logic [2:0]      row_count;
  logic [3:0]      row_code;

  // Two-flop synchroniser; idle value is all columns released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  // Columns are read on the last dwell cycle so the row drive has settled through the sync.
  assign sample   = (div_q == DivW'(SCAN_DIV - 1));
  assign contacts = ~col_sync_q;

  // Contacts in the current row; lowest active column supplies the code.
  always_comb begin
    row_count = '0;
    row_code  = keymap(row_idx_q, 2'd0);
    for (int c = 3; c >= 0; c--) begin
      if (contacts[c]) begin
        row_count = row_count + 3'd1;
        row_code  = keymap(row_idx_q, 2'(c));
      end
    end
  end

  always_comb begin
    div_d       = sample ? '0 : div_q + 1'b1;
    row_idx_d   = sample ? row_idx_q + 2'd1 : row_idx_q;
    acc_count_d = acc_count_q;
    acc_code_d  = acc_code_q;
    if (sample) begin
      if (row_idx_q == 2'd3) begin
        // Row 3 closes the pass; its contacts go straight to the outputs.
        acc_count_d = '0;
        acc_code_d  = '0;
      end else begin
        acc_count_d = acc_count_q + {2'b00, row_count};
        if ((acc_count_q == '0) && (row_count != '0)) begin
          acc_code_d = row_code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      row_idx_q   <= '0;
      acc_count_q <= '0;
      acc_code_q  <= '0;
    end else begin
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      acc_count_q <= acc_count_d;
      acc_code_q  <= acc_code_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_idx_q);
  assign pass_done = sample && (row_idx_q == 2'd3);
  // At most 16 contacts per pass, so 5 bits never overflow.
  assign key_count = acc_count_q + {2'b00, row_count};
  assign key_code  = (acc_count_q != '0) ? acc_code_q : row_code;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner, debouncer and encoder feeding the calculator control FSM.
//   A key is accepted after DEBOUNCE_SCANS identical single-contact passes and released
//   after DEBOUNCE_SCANS empty passes. The consumer captures pressedkey on kbEN falling.
// Build option:
//   KEYPAD_REPEAT_EN  when defined, a held key dips kbEN low for one pass every
//                     REPEAT_SCANS passes (auto-repeat). Undefined: one event per press.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active-low
//   col_n       in   [3:0] keypad columns, pulled up, 0 = contact
//   row_n       out  [3:0] keypad row drive, one bit low at a time
//   kbEN        out  high while a key is accepted
//   pressedkey  out  [3:0] code of the accepted key
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       kbEN,
  output logic [3:0] pressedkey
);

  if ((SCAN_DIV < 4) || (DEBOUNCE_SCANS < 1) || (REPEAT_SCANS < 1)) begin : g_param_check
    $error("keypad_encoder: SCAN_DIV must be >= 4 and scan counts must be >= 1");
  end

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  logic            pass_done;
  logic [4:0]      key_count;
  logic [3:0]      key_code;
  logic            single_pass, empty_pass;

  kp_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d;
  logic            kb_en_q, kb_en_d;
  logic [3:0]      key_q, key_d;
  logic            deb_done;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
  logic [RepW-1:0] rep_q, rep_d, rep_inc;
  // rep_q is cleared on reaching REPEAT_SCANS, so the increment cannot wrap.
  assign rep_inc = rep_q + 1'b1;
`endif

  keypad_row_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .pass_done (pass_done),
    .key_count (key_count),
    .key_code  (key_code)
  );

  assign single_pass = (key_count == 5'd1);
  assign empty_pass  = (key_count == 5'd0);
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign deb_done    = (cnt_inc >= CntW'(DEBOUNCE_SCANS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    kb_en_d = kb_en_q;
    key_d   = key_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    if (pass_done) begin
      unique case (state_q)
        StScan: begin
          if (single_pass) begin
            cand_d = key_code;
            cnt_d  = CntW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d = StHeld;
              kb_en_d = 1'b1;
              key_d   = key_code;
              cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              state_d = StDebPress;
            end
          end
        end
        StDebPress: begin
          if (single_pass && (key_code == cand_q)) begin
            cnt_d = cnt_inc;
            if (deb_done) begin
              state_d = StHeld;
              kb_en_d = 1'b1;
              key_d   = cand_q;
              cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d   = '0;
`endif
            end
          end else begin
            state_d = StScan;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          // No rollover: only an empty pass matters while a key is held.
          if (empty_pass) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = StScan;
              kb_en_d = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = StDebRel;
              cnt_d   = CntW'(1);
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            // A dip lasts exactly one pass, then kbEN returns high.
            kb_en_d = 1'b1;
            if (rep_inc >= RepW'(REPEAT_SCANS)) begin
              rep_d   = '0;
              kb_en_d = 1'b0;
            end else begin
              rep_d   = rep_inc;
            end
          end
`endif
        end
        StDebRel: begin
          if (empty_pass) begin
            cnt_d = cnt_inc;
            if (deb_done) begin
              state_d = StScan;
              kb_en_d = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            state_d = StHeld;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            // Release aborted during a dip: restore the level and restart the repeat period.
            kb_en_d = 1'b1;
            rep_d   = '0;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StScan;
      cnt_q   <= '0;
      cand_q  <= '0;
      kb_en_q <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      kb_en_q <= kb_en_d;
      key_q   <= key_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign kbEN       = kb_en_q;
  assign pressedkey = key_q;

endmodule

// File: tb/tb_keypad_encoder.sv
`timescale 1ns/1ps
module tb_keypad_encoder;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int unsigned REP      = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       kbEN;
  logic [3:0] pressedkey;

  // One bit per key, index row*4+col.
  logic [15:0] key_mask = '0;

  int checks = 0;
  int errors = 0;

  // Expected code per key index, read off the keypad legend.
  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hC, 4'h4, 4'h5, 4'h6, 4'hD,
                                4'h7, 4'h8, 4'h9, 4'hE, 4'hB, 4'h0, 4'hA, 4'hF};

  keypad_encoder #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_n      (col_n),
    .row_n      (row_n),
    .kbEN       (kbEN),
    .pressedkey (pressedkey)
  );

  always #5 clk = ~clk;

  // Passive keypad matrix: a pressed key shorts its column to its row.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_en(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (kbEN === val) ok = 1'b1;
    end
  endtask

  // Consumer-side monitor: counts kbEN edges and records pressedkey at each fall.
  logic       prev_en = 1'b0;
  logic [3:0] rise_key = '0;
  int         rises = 0;
  int         falls = 0;
  logic [3:0] fall_keys [$];

  initial begin
    forever begin
      @(negedge clk);
      if (kbEN && !prev_en) begin
        rises++;
        rise_key = pressedkey;
      end else if (kbEN && reset) begin
        check("key_stable", {28'd0, pressedkey}, {28'd0, rise_key});
      end
      if (!kbEN && prev_en) begin
        falls++;
        fall_keys.push_back(pressedkey);
        if (reset) check("key_at_fall", {28'd0, pressedkey}, {28'd0, rise_key});
      end
      check("row_onehot", $countones(~row_n), 1);
      prev_en = kbEN;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] mask;
    int          hold;
    logic        exp_en;
    logic [3:0]  exp_key;
    string       name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit          ok;
    int          r0, f0, low, exp_dips, held, n, idx, a, b, kind, hold;
    logic [15:0] m;
    logic [3:0]  exp_keys [$];

    vecs[0] = '{mask: 16'h0040, hold: 48, exp_en: 1'b1, exp_key: 4'h6, name: "press6"};
    vecs[1] = '{mask: 16'h0040, hold: 52, exp_en: 1'b1, exp_key: 4'h6, name: "held6"};
    vecs[2] = '{mask: 16'h0000, hold: 48, exp_en: 1'b0, exp_key: 4'h6, name: "release6"};
    vecs[3] = '{mask: 16'h0028, hold: 80, exp_en: 1'b0, exp_key: 4'h6, name: "multi_5_plus"};
    vecs[4] = '{mask: 16'h0020, hold: 48, exp_en: 1'b1, exp_key: 4'h5, name: "drop_plus"};
    vecs[5] = '{mask: 16'h0000, hold: 48, exp_en: 1'b0, exp_key: 4'h5, name: "release5"};

    // Reset state and first pass
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_row_n", {28'd0, row_n}, 32'hE);
    check("reset_kben", {31'd0, kbEN}, 0);
    check("reset_key", {28'd0, pressedkey}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      repeat (SCAN_DIV) @(posedge clk);
      #1;
      check("scan_row_n", {28'd0, row_n}, {28'd0, ~(4'b0001 << (k % 4))});
    end

    // Table: clean press of '6', then '5' + '+' together
    r0 = rises;
    f0 = falls;
    for (int i = 0; i < 6; i++) begin
      key_mask = vecs[i].mask;
      repeat (vecs[i].hold) @(posedge clk);
      #1;
      check({vecs[i].name, "_en"}, {31'd0, kbEN}, {31'd0, vecs[i].exp_en});
      check({vecs[i].name, "_key"}, {28'd0, pressedkey}, {28'd0, vecs[i].exp_key});
    end
    check("table_rises", rises - r0, 2);
    check("table_falls", falls - f0, 2);

    // Bounce on '0', aligned to a pass start
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (row_n == 4'b0111) ok = 1'b1;
    end
    check("align_row3", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (row_n == 4'b1110) ok = 1'b1;
    end
    check("align_row0", ok, 1);
    r0 = rises;
    f0 = falls;
    for (int i = 0; i < 8; i++) begin
      key_mask = (i % 2 == 0) ? 16'h2000 : 16'h0000;
      repeat (5) @(posedge clk);
      #1;
    end
    key_mask = 16'h2000;
    repeat (80) @(posedge clk);
    #1;
    check("bounce_rises", rises - r0, 1);
    check("bounce_falls", falls - f0, 0);
    check("bounce_en", {31'd0, kbEN}, 1);
    check("bounce_key", {28'd0, pressedkey}, 0);
    key_mask = '0;
    repeat (48) @(posedge clk);
    #1;
    check("bounce_release_en", {31'd0, kbEN}, 0);

    // Reset while '=' is accepted and still held
    key_mask = 16'h4000;
    wait_en(1'b1, 64, ok);
    check("eq_press_wait", ok, 1);
    check("eq_press_key", {28'd0, pressedkey}, 32'hA);
    #1;
    reset = 1'b0;
    #1;
    check("reset_async_en", {31'd0, kbEN}, 0);
    check("reset_async_key", {28'd0, pressedkey}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_en(1'b1, 80, ok);
    check("eq_again_wait", ok, 1);
    check("eq_again_key", {28'd0, pressedkey}, 32'hA);
    key_mask = '0;
    repeat (48) @(posedge clk);
    #1;
    check("eq_release_en", {31'd0, kbEN}, 0);

    // Hold '1' for many passes: auto-repeat dips only with the repeat build
    key_mask = 16'h0001;
    wait_en(1'b1, 64, ok);
    check("one_press_wait", ok, 1);
    f0 = falls;
    low = 0;
    for (int i = 0; i < 184; i++) begin
      @(posedge clk);
      #1;
      if (!kbEN) low++;
    end
`ifdef KEYPAD_REPEAT_EN
    exp_dips = 2;
`else
    exp_dips = 0;
`endif
    check("repeat_dips", falls - f0, exp_dips);
    check("repeat_low_cycles", low, exp_dips * 16);
    check("repeat_key", {28'd0, pressedkey}, 1);
    key_mask = '0;
    repeat (64) @(posedge clk);
    #1;
    check("one_release_en", {31'd0, kbEN}, 0);

    // Random stable key patterns against a press/release event model
    held = -1;
    fall_keys.delete();
    for (int seg = 0; seg < 30; seg++) begin
      kind = $urandom_range(0, 99);
      if (kind < 35) begin
        m = '0;
      end else if (kind < 80) begin
        m = 16'(1) << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        m = (16'(1) << a) | (16'(1) << b);
      end
      key_mask = m;
      hold = $urandom_range(90, 140);
      repeat (hold) @(posedge clk);
      #1;
      n = $countones(m);
      if (held < 0 && n == 1) begin
        idx = 0;
        for (int i = 0; i < 16; i++) if (m[i]) idx = i;
        held = code_tab[idx];
      end else if (held >= 0 && n == 0) begin
        exp_keys.push_back(4'(held));
        held = -1;
      end
`ifdef KEYPAD_REPEAT_EN
      if (held < 0) check("rand_en", {31'd0, kbEN}, 0);
`else
      check("rand_en", {31'd0, kbEN}, (held >= 0) ? 1 : 0);
`endif
      if (held >= 0) check("rand_key", {28'd0, pressedkey}, held);
    end
    key_mask = '0;
    repeat (64) @(posedge clk);
    #1;
    if (held >= 0) exp_keys.push_back(4'(held));
    check("rand_final_en", {31'd0, kbEN}, 0);
`ifdef KEYPAD_REPEAT_EN
    check("rand_events_min", (fall_keys.size() >= exp_keys.size()) ? 1 : 0, 1);
`else
    check("rand_events", fall_keys.size(), exp_keys.size());
    for (int i = 0; i < exp_keys.size() && i < fall_keys.size(); i++) begin
      check("rand_event_key", {28'd0, fall_keys[i]}, {28'd0, exp_keys[i]});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
